// File: rtl/simon_seq_ctrl_pkg.sv
// Shared state encoding and width helpers for the Simon sequence controller
// and the display/menu logic that sits around it.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT,
    ST_RELEASE,
    ST_WIN,
    ST_LOSE
  } simon_state_t;

  // Widest channel count onehot() can encode; callers cast down to NUM_CH.
  localparam int OH_MAX = 64;

  function automatic int cw_of(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int lw_of(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int aw_of(input int max_len);
    return (max_len > 2) ? $clog2(max_len) : 1;
  endfunction

  function automatic int tw_of(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic logic [OH_MAX-1:0] onehot(input logic [31:0] sym);
    return {{(OH_MAX-1){1'b0}}, 1'b1} << sym;
  endfunction

endpackage

// File: rtl/simon_seq_ctrl_if.sv
// Player-facing bundle of the Simon controller: buttons and random symbol in,
// LEDs and game status out.
interface simon_seq_ctrl_if #(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 32
) ();
  import simon_pkg::*;

  localparam int CW = cw_of(NUM_CH);
  localparam int LW = lw_of(MAX_LEN);

  logic [NUM_CH-1:0] btn;
  logic [CW-1:0]     rand_sym;
  logic [NUM_CH-1:0] led;
  logic              round_start;
  logic              win;
  logic              lose;
  logic [LW-1:0]     score;

  modport master (
    output btn, rand_sym,
    input  led, round_start, win, lose, score
  );

  modport slave (
    input  btn, rand_sym,
    output led, round_start, win, lose, score
  );

endinterface

// File: rtl/simon_seq_ctrl_press_detect.sv
// Button press-edge detector: a press is any button going active while all
// buttons were released on the previous cycle; valid only for a single button.
module simon_press_detect
  import simon_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         btn,
  output logic [NUM_CH-1:0]         btn_q,
  output logic                      press,
  output logic                      valid,
  output logic [cw_of(NUM_CH)-1:0]  sym
);

  localparam int CW = cw_of(NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn;
  end

  assign press = (btn_q == '0) && (btn != '0);
  assign valid = press && $onehot(btn);

  always_comb begin
    sym = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (btn[i]) sym = CW'(i);
    end
  end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon-Says game controller: grows a random symbol sequence one entry per
// round, plays it back on the LEDs and checks the player's button presses.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_LEN     = 32,
  parameter int LED_ON_CYC  = 50_000_000,
  parameter int LED_GAP_CYC = 12_500_000,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic            clk,
  input  logic            rst,
  simon_seq_ctrl_if.slave bus
);

  localparam int CW = cw_of(NUM_CH);
  localparam int LW = lw_of(MAX_LEN);
  localparam int AW = aw_of(MAX_LEN);
  localparam int TW = tw_of(LED_ON_CYC, LED_GAP_CYC, TIMEOUT_CYC);

  localparam logic [TW-1:0] ON_LAST  = TW'(LED_ON_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(LED_GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC);

  simon_state_t      state;
  logic [LW-1:0]     len;
  logic [LW-1:0]     idx;
  logic [LW-1:0]     score;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     seq [MAX_LEN];
  logic [CW-1:0]     seq_rd;
  logic [CW-1:0]     sym_mod;
  logic [NUM_CH-1:0] seq_oh;

  logic [NUM_CH-1:0] btn_q;
  logic              press;
  logic              valid;
  logic [CW-1:0]     sym;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  simon_press_detect #(
    .NUM_CH (NUM_CH)
  ) u_press (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .btn_q (btn_q),
    .press (press),
    .valid (valid),
    .sym   (sym)
  );

  assign sym_mod = CW'(32'(bus.rand_sym) % NUM_CH);
  assign seq_rd  = seq[idx[AW-1:0]];
  assign seq_oh  = NUM_CH'(onehot(32'(seq_rd)));

  // Sequence store carries no reset; only entries below len are ever read.
  always_ff @(posedge clk) begin
    if (state == ST_APPEND) seq[len[AW-1:0]] <= sym_mod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      len   <= '0;
      idx   <= '0;
      score <= '0;
      timer <= '0;
    end else begin
      timer <= sat_inc(timer);
      case (state)
        ST_IDLE: if (press) begin
          state <= ST_APPEND;
          len   <= '0;
          score <= '0;
          timer <= '0;
        end
        ST_APPEND: begin
          state <= ST_SHOW_ON;
          len   <= len + 1'b1;
          idx   <= '0;
          timer <= '0;
        end
        ST_SHOW_ON: if (timer == ON_LAST) begin
          state <= ST_SHOW_OFF;
          timer <= '0;
        end
        ST_SHOW_OFF: if (timer == GAP_LAST) begin
          timer <= '0;
          if (idx == len - 1'b1) begin
            state <= ST_WAIT;
            idx   <= '0;
          end else begin
            state <= ST_SHOW_ON;
            idx   <= idx + 1'b1;
          end
        end
        ST_WAIT: if (press) begin
          timer <= '0;
          state <= (valid && sym == seq_rd) ? ST_RELEASE : ST_LOSE;
        end else if (TIMEOUT_CYC != 0 && timer == TO_LAST) begin
          state <= ST_LOSE;
          timer <= '0;
        end
        // Raw btn here: the round only moves on once every button is up.
        ST_RELEASE: if (bus.btn == '0) begin
          timer <= '0;
          if (idx < len - 1'b1) begin
            state <= ST_WAIT;
            idx   <= idx + 1'b1;
          end else begin
            score <= len;
            state <= (len == LW'(MAX_LEN)) ? ST_WIN : ST_APPEND;
          end
        end
        ST_WIN, ST_LOSE: if (press) begin
          state <= ST_IDLE;
          timer <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.led         = '1;
    bus.round_start = 1'b0;
    bus.win         = 1'b0;
    bus.lose        = 1'b0;
    case (state)
      ST_APPEND: begin
        bus.led         = '0;
        bus.round_start = 1'b1;
      end
      ST_SHOW_ON:           bus.led = seq_oh;
      ST_SHOW_OFF:          bus.led = '0;
      ST_WAIT, ST_RELEASE:  bus.led = btn_q;
      ST_LOSE: begin
        bus.led  = seq_oh;
        bus.lose = 1'b1;
      end
      ST_WIN:               bus.win = 1'b1;
      default: ;
    endcase
  end

  assign bus.score = score;

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Parametrised Simon-Says game controller. Successor to the fixed 4-button controller: configurable channel count and maximum sequence length, an internal sequence store, cycle-accurate LED on/gap timing, button press-edge detection with multi-press rejection, an input timeout, a win condition at full depth, and a score output. Sits between the debounced button inputs, the random-symbol source and the LED/display drivers.

## Interface
- NUM_CH, 4, number of buttons/LEDs; ≥2. CW = $clog2(NUM_CH).
- MAX_LEN, 32, maximum sequence length; reaching it wins. LW = $clog2(MAX_LEN+1).
- LED_ON_CYC, 50_000_000, cycles one symbol's LED is lit during playback; ≥1.
- LED_GAP_CYC, 12_500_000, dark cycles after each symbol; ≥1.
- TIMEOUT_CYC, 250_000_000, max cycles to wait for a press; 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn  in  NUM_CH  debounced buttons, active-high.
- rand_sym  in  CW  random symbol, sampled only in APPEND; values ≥NUM_CH are reduced modulo NUM_CH.
- led  out  NUM_CH  LED drive.
- round_start  out  1  one-cycle pulse when a round begins.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.
- score  out  LW  number of fully completed rounds.

## Operation
- Press event: btn_q is btn registered once; press = (btn_q == 0) && (btn != 0). Valid press = press with btn one-hot; sym = index of the set bit.
- States: IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT, RELEASE, WIN, LOSE.
- IDLE: led = all ones. Press event (any) → APPEND; len ← 0, score ← 0.
- APPEND: seq[len] ← rand_sym mod NUM_CH; len ← len+1; idx ← 0; timer ← 0; round_start = 1 → SHOW_ON.
- SHOW_ON: led = onehot(seq[idx]). After LED_ON_CYC cycles → SHOW_OFF. Buttons are ignored.
- SHOW_OFF: led = 0. After LED_GAP_CYC cycles: if idx == len−1 → WAIT with idx ← 0; else idx+1 → SHOW_ON.
- WAIT: led = btn_q. Invalid press (multi-bit), or sym ≠ seq[idx] → LOSE. Correct press → RELEASE. No press for TIMEOUT_CYC cycles (TIMEOUT_CYC ≠ 0) → LOSE.
- RELEASE: led = btn_q. Waits for btn == 0 with no timeout. Then:
  - if idx < len−1: idx+1 → WAIT, timer cleared.
  - else if len == MAX_LEN: score ← len → WIN.
  - else: score ← len → APPEND.
- LOSE: lose = 1; led = onehot(seq[idx]), showing the expected symbol. Press event → IDLE.
- WIN: win = 1; led = all ones. Press event → IDLE.
- Sequence store: MAX_LEN × CW registers, not reset; only entries < len are ever read.

## Timing
- Reset values: state IDLE, led = all ones from the first post-reset cycle, round_start/win/lose = 0, score = 0, len = 0, idx = 0, timer = 0, btn_q = 0.
- Reset mid-operation aborts any state at the next clock edge and returns to IDLE.
- All outputs are Moore-decoded from registered state/idx/btn_q. There is no combinational path from btn to any output.
- The first SHOW_ON cycle is the cycle after round_start. A round's playback lasts exactly len × (LED_ON_CYC + LED_GAP_CYC) cycles.
- Press detection latency: state changes on the edge after the cycle where press is true.
- A button already held on entry to WAIT produces no press (btn_q ≠ 0). The player must release first.
- The timer is LW_T = $clog2(max of parameters +1) bits and saturates. It is cleared on every state change.
- The press event that exits LOSE/WIN to IDLE does not also start a game. A new press from IDLE is required.

## Structure
- Package simon_pkg: state enum, onehot(sym) function, and the CW/LW width derivations used by the display block.
- Sub-module simon_press_detect (parameter NUM_CH): owns btn_q and outputs press, valid, sym. It is reused by the menu logic.

## Test plan
- NUM_CH=4, ON=3, GAP=2, rand_sym=2. Reset, then press btn=0001 → round_start 1 cycle later. led=0100 for 3 cycles, then 0000 for 2 cycles, then WAIT.
- Round 1: press 0100, release → score=1, round_start. Next rand_sym=1: playback shows 0100 then 0010.
- Wrong symbol in round 2 (press 1000 at idx 0) → lose=1, led=0100, score=1. Press any button → IDLE, led=1111.
- Press 0011 simultaneously in WAIT → LOSE. Hold a button across the SHOW→WAIT boundary → no press is registered.
- TIMEOUT_CYC=10, no press → lose asserts exactly 11 cycles after WAIT entry. With TIMEOUT_CYC=0, 1000 idle cycles → still in WAIT.
- MAX_LEN=3, all rounds answered correctly → win=1, score=3, no 4th round_start. Assert rst during SHOW_ON → IDLE, score=0 next cycle.
